// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: default widths, reset PC, NOP encoding and
// the fetch-side enums.
package rv32i_pkg;

    localparam int          ADDRESS_WIDTH_DEF = 32;
    localparam int          DATA_WIDTH_DEF    = 32;
    localparam logic [31:0] RESET_PC_DEF      = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic {
        FETCH_BOOT = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_SEL_HOLD     = 2'd0,
        PC_SEL_INC      = 2'd1,
        PC_SEL_REDIRECT = 2'd2,
        PC_SEL_RESET    = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register with its next-PC select
// (reset value / sequential +4 / redirect target / hold).
module pc_reg
    import rv32i_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(RESET_PC_DEF)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  pc_sel_e                  pc_sel_i,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target_i,
    output logic [ADDRESS_WIDTH-1:0] pc_o,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_o
);

    logic [ADDRESS_WIDTH-1:0] pc_q;
    logic [ADDRESS_WIDTH-1:0] pc_d;

    // Modulo-2^ADDRESS_WIDTH increment: the top word wraps to zero.
    assign pc_plus4_o = pc_q + ADDRESS_WIDTH'(4);
    assign pc_o       = pc_q;

    always_comb begin
        pc_d = pc_q;
        case (pc_sel_i)
            PC_SEL_INC:      pc_d = pc_plus4_o;
            PC_SEL_REDIRECT: pc_d = redirect_target_i;
            PC_SEL_RESET:    pc_d = RESET_PC;
            default:         pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, instruction-memory address and IF/ID register.
// Optional fetch-fault checking is enabled with `define FETCH_FAULT_CHECK_EN.
//
// state | meaning
// BOOT  | first cycle after reset: fetch at RESET_PC unconditionally
// RUN   | normal operation: redirect > stall > flush > sequential fetch
module fetch_stage
    import rv32i_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter int                       DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(RESET_PC_DEF),
    parameter int                       IMEM_BYTES    = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     redirect_en,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0]    imem_instr,
    output logic [DATA_WIDTH-1:0]    if_id_instr,
    output logic [ADDRESS_WIDTH-1:0] if_id_pc,
    output logic [ADDRESS_WIDTH-1:0] if_id_pc_plus4,
    output logic                     if_id_valid,
    output logic                     fetch_fault
);

    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_INSTR);

    if (IMEM_BYTES < 4 || (IMEM_BYTES % 4) != 0) begin : g_bad_imem_bytes
        $error("fetch_stage: IMEM_BYTES must be a positive multiple of 4");
    end

    fetch_state_e             state_q;
    fetch_state_e             state_d;
    pc_sel_e                  pc_sel;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [ADDRESS_WIDTH-1:0] pc_plus4;
    logic                     fetch_req;
    logic                     fetch_bad;
    logic                     fault_hold;
    logic                     ifid_load;
    logic                     ifid_bubble;

    logic [DATA_WIDTH-1:0]    instr_q;
    logic [ADDRESS_WIDTH-1:0] ifid_pc_q;
    logic [ADDRESS_WIDTH-1:0] ifid_pc4_q;
    logic                     valid_q;

    pc_reg #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .RESET_PC      (RESET_PC)
    ) u_pc_reg (
        .clk_i             (clk),
        .rst_i             (rst),
        .pc_sel_i          (pc_sel),
        .redirect_target_i (redirect_target),
        .pc_o              (pc),
        .pc_plus4_o        (pc_plus4)
    );

    assign imem_addr = pc;

`ifdef FETCH_FAULT_CHECK_EN
    localparam logic [ADDRESS_WIDTH-1:0] IMEM_LAST = ADDRESS_WIDTH'(IMEM_BYTES - 4);

    logic fault_q;

    assign fetch_bad  = (pc[1:0] != 2'b00) || (pc > IMEM_LAST);
    assign fault_hold = fault_q;
    assign fetch_fault = fault_q;

    // Sticky until a redirect moves the PC somewhere else.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (pc_sel == PC_SEL_REDIRECT) begin
            fault_q <= 1'b0;
        end else if (fetch_req && fetch_bad) begin
            fault_q <= 1'b1;
        end
    end
`else
    assign fetch_bad   = 1'b0;
    assign fault_hold  = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_sel      = PC_SEL_HOLD;
        fetch_req   = 1'b0;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;

        case (state_q)
            FETCH_BOOT: begin
                // Nothing downstream can legitimately stall or redirect yet.
                state_d   = FETCH_RUN;
                fetch_req = 1'b1;
            end
            default: begin
                if (redirect_en) begin
                    pc_sel      = PC_SEL_REDIRECT;
                    ifid_bubble = 1'b1;
                end else if (stall) begin
                    ifid_bubble = flush;
                end else if (fault_hold) begin
                    ifid_bubble = 1'b1;
                end else if (flush) begin
                    pc_sel      = PC_SEL_INC;
                    ifid_bubble = 1'b1;
                end else begin
                    fetch_req = 1'b1;
                end
            end
        endcase

        if (fetch_req) begin
            if (fetch_bad) begin
                ifid_bubble = 1'b1;
            end else begin
                pc_sel    = PC_SEL_INC;
                ifid_load = 1'b1;
            end
        end
    end

    // Bubbles only clear instr/valid; the PC fields keep their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q    <= NOP;
            ifid_pc_q  <= '0;
            ifid_pc4_q <= '0;
            valid_q    <= 1'b0;
        end else if (ifid_load) begin
            instr_q    <= imem_instr;
            ifid_pc_q  <= pc;
            ifid_pc4_q <= pc_plus4;
            valid_q    <= 1'b1;
        end else if (ifid_bubble) begin
            instr_q    <= NOP;
            valid_q    <= 1'b0;
        end
    end

    assign if_id_instr    = instr_q;
    assign if_id_pc       = ifid_pc_q;
    assign if_id_pc_plus4 = ifid_pc4_q;
    assign if_id_valid    = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, randomized run
// against a behavioural model, and hand sequences for wrap and fault handling.
module tb_fetch_stage;
    import rv32i_pkg::*;

    localparam int          IMEM_BYTES = 4096;
    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [31:0] RST_PC     = 32'h0000_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, flush, redirect_en;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr, imem_instr, if_id_instr, if_id_pc, if_id_pc_plus4;
    logic        if_id_valid, fetch_fault;

    logic        rst2;
    logic [31:0] imem_addr2, imem_instr2, if_id_instr2, if_id_pc2, if_id_pc_plus42;
    logic        if_id_valid2, fetch_fault2;

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    assign imem_instr  = mem_word(imem_addr);
    assign imem_instr2 = mem_word(imem_addr2);

    fetch_stage #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .RESET_PC      (RST_PC),
        .IMEM_BYTES    (IMEM_BYTES)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .redirect_en     (redirect_en),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_pc_plus4  (if_id_pc_plus4),
        .if_id_valid     (if_id_valid),
        .fetch_fault     (fetch_fault)
    );

    fetch_stage #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .RESET_PC      (32'hFFFF_FFF8),
        .IMEM_BYTES    (IMEM_BYTES)
    ) dut_wrap (
        .clk             (clk),
        .rst             (rst2),
        .stall           (1'b0),
        .flush           (1'b0),
        .redirect_en     (1'b0),
        .redirect_target (32'h0),
        .imem_addr       (imem_addr2),
        .imem_instr      (imem_instr2),
        .if_id_instr     (if_id_instr2),
        .if_id_pc        (if_id_pc2),
        .if_id_pc_plus4  (if_id_pc_plus42),
        .if_id_valid     (if_id_valid2),
        .fetch_fault     (fetch_fault2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic s, input logic f,
                         input logic re, input logic [31:0] t);
        rst             = r;
        stall           = s;
        flush           = f;
        redirect_en     = re;
        redirect_target = t;
    endtask

    // Behavioural model: what IF/ID and the PC should hold after each edge.
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4;
    logic        m_valid, m_fault, m_boot;

    task automatic model_bubble();
        m_instr = NOP;
        m_valid = 1'b0;
    endtask

    task automatic model_fetch();
`ifdef FETCH_FAULT_CHECK_EN
        if ((m_pc % 4) != 0 || m_pc > 32'(IMEM_BYTES - 4)) begin
            m_fault = 1'b1;
            model_bubble();
            return;
        end
`endif
        m_instr = mem_word(m_pc);
        m_ipc   = m_pc;
        m_ipc4  = m_pc + 32'd4;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
    endtask

    task automatic model_edge(input logic r, input logic s, input logic f,
                              input logic re, input logic [31:0] t);
        if (r) begin
            m_pc    = RST_PC;
            m_instr = NOP;
            m_ipc   = 32'h0;
            m_ipc4  = 32'h0;
            m_valid = 1'b0;
            m_fault = 1'b0;
            m_boot  = 1'b1;
        end else if (m_boot) begin
            m_boot = 1'b0;
            model_fetch();
        end else if (re) begin
            m_pc    = t;
            m_fault = 1'b0;
            model_bubble();
        end else if (s) begin
            if (f) model_bubble();
        end else if (m_fault) begin
            model_bubble();
        end else if (f) begin
            m_pc = m_pc + 32'd4;
            model_bubble();
        end else begin
            model_fetch();
        end
    endtask

    typedef struct {
        logic        r, s, f, re;
        logic [31:0] tgt;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc, exp_pc4;
    } vec_t;

    vec_t vecs[19];

    initial begin
        logic        r, s, f, re;
        logic [31:0] t;

        rst2 = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 32'h0,  32'h0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 32'h0,  32'h0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h4,   1'b1, 32'h0,  32'h4};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h8,   1'b1, 32'h4,  32'h8};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'hC,   1'b1, 32'h8,  32'hC};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'hC,   1'b1, 32'h8,  32'hC};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'hC,   1'b1, 32'h8,  32'hC};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'hC,   1'b1, 32'h8,  32'hC};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h10,  1'b1, 32'hC,  32'h10};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h40,  32'h40,  1'b0, 32'h0,  32'h0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h44,  1'b1, 32'h40, 32'h44};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h80,  32'h80,  1'b0, 32'h0,  32'h0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h84,  1'b1, 32'h80, 32'h84};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   32'h84,  1'b0, 32'h0,  32'h0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h88,  1'b1, 32'h84, 32'h88};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   32'h8C,  1'b0, 32'h0,  32'h0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h90,  1'b1, 32'h8C, 32'h90};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 32'h0,   1'b0, 32'h0,  32'h0};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h4,   1'b1, 32'h0,  32'h4};

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].r, vecs[i].s, vecs[i].f, vecs[i].re, vecs[i].tgt);
            cycle();
            chk("vec_imem_addr", imem_addr, vecs[i].exp_addr);
            chk1("vec_valid", if_id_valid, vecs[i].exp_valid);
            chk("vec_instr", if_id_instr, vecs[i].exp_valid ? mem_word(vecs[i].exp_pc) : NOP);
            chk1("vec_fault", fetch_fault, 1'b0);
            if (vecs[i].exp_valid || vecs[i].r) begin
                chk("vec_pc", if_id_pc, vecs[i].exp_pc);
                chk("vec_pc_plus4", if_id_pc_plus4, vecs[i].exp_pc4);
            end
        end

        for (int n = 0; n < 3000; n++) begin
            r  = (n == 0) || ($urandom_range(0, 63) == 0);
            s  = ($urandom_range(0, 3) == 0);
            f  = ($urandom_range(0, 5) == 0);
            re = ($urandom_range(0, 7) == 0);
            t  = ($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, IMEM_BYTES / 4 - 1) * 4;
            drive(r, s, f, re, t);
            model_edge(r, s, f, re, t);
            cycle();
            chk("rnd_imem_addr", imem_addr, m_pc);
            chk1("rnd_valid", if_id_valid, m_valid);
            chk("rnd_instr", if_id_instr, m_instr);
            chk1("rnd_fault", fetch_fault, m_fault);
            if (m_valid) begin
                chk("rnd_pc", if_id_pc, m_ipc);
                chk("rnd_pc_plus4", if_id_pc_plus4, m_ipc4);
            end
        end

        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        chk("seq_boot_pc", if_id_pc, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h102);
        cycle();
        chk("seq_redir_addr", imem_addr, 32'h102);
        chk1("seq_redir_valid", if_id_valid, 1'b0);
        chk1("seq_redir_fault", fetch_fault, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
`ifdef FETCH_FAULT_CHECK_EN
        chk1("seq_fault_set", fetch_fault, 1'b1);
        chk1("seq_fault_valid", if_id_valid, 1'b0);
        chk("seq_fault_instr", if_id_instr, NOP);
        chk("seq_fault_pc_hold", imem_addr, 32'h102);
        cycle();
        chk1("seq_fault_sticky", fetch_fault, 1'b1);
        chk("seq_fault_pc_hold2", imem_addr, 32'h102);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
        cycle();
        chk1("seq_fault_clear", fetch_fault, 1'b0);
        chk("seq_fault_redir_addr", imem_addr, 32'h100);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        chk1("seq_resume_valid", if_id_valid, 1'b1);
        chk("seq_resume_pc", if_id_pc, 32'h100);
        chk("seq_resume_addr", imem_addr, 32'h104);
`else
        chk1("seq_unmasked_valid", if_id_valid, 1'b1);
        chk("seq_unmasked_pc", if_id_pc, 32'h102);
        chk("seq_unmasked_instr", if_id_instr, mem_word(32'h102));
        chk("seq_unmasked_addr", imem_addr, 32'h106);
        chk1("seq_unmasked_fault", fetch_fault, 1'b0);

        chk1("wrap_reset_valid", if_id_valid2, 1'b0);
        chk("wrap_reset_addr", imem_addr2, 32'hFFFF_FFF8);
        rst2 = 1'b0;
        cycle();
        chk("wrap_pc0", if_id_pc2, 32'hFFFF_FFF8);
        chk1("wrap_valid0", if_id_valid2, 1'b1);
        chk("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);
        cycle();
        chk("wrap_pc1", if_id_pc2, 32'hFFFF_FFFC);
        chk("wrap_pc1_plus4", if_id_pc_plus42, 32'h0);
        chk("wrap_addr1", imem_addr2, 32'h0);
        cycle();
        chk("wrap_pc2", if_id_pc2, 32'h0);
        chk("wrap_instr2", if_id_instr2, mem_word(32'h0));
        chk("wrap_addr2", imem_addr2, 32'h4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
